// File: rtl/dfr_axi_cfg_slave.sv
// dfr_axi_cfg_slave: AXI4-Lite responder for the DFR config registers and memory port.
// Optional DFR_AXI_BUSY_PROTECT_EN: reject parameter/memory writes while the core is busy.
module dfr_axi_cfg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 30,
    parameter int MEM_ADDR_WIDTH     = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [31:0]                   ctrl_reg,
    output logic [31:0]                   num_init_samples,
    output logic [31:0]                   num_train_samples,
    output logic [31:0]                   num_test_samples,
    output logic [31:0]                   num_steps_per_sample,
    output logic [31:0]                   num_init_steps,
    output logic [31:0]                   num_train_steps,
    output logic [31:0]                   num_test_steps,
    output logic                          start,
    input  logic [31:0]                   debug_in,
    input  logic                          busy,
    output logic [1:0]                    mem_sel,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [31:0]                   mem_rdata
);

    localparam int OW = C_S_AXI_ADDR_WIDTH - 6;

    typedef enum logic [2:0] {
        IDLE, WR_ACK, WR_RESP, RD_ACK, RD_MEM, RD_RESP
    } state_t;

    state_t state, state_nxt;

    logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    resp_q;

    logic [5:0]    region;
    logic [OW-1:0] off;
    logic          is_reg;
    logic          is_mem;
    logic          reg_ok;
    logic [3:0]    reg_idx;
    logic          wr_blocked;
    logic          wr_go;
    logic [31:0]   reg_rd;
    logic          unused_in;

    assign region  = addr_q[C_S_AXI_ADDR_WIDTH-1 -: 6];
    assign off     = addr_q[OW-1:0];
    assign is_reg  = (region == 6'h00);
    assign is_mem  = (region >= 6'h01) && (region <= 6'h04);
    assign reg_idx = off[5:2];
    assign reg_ok  = is_reg && (off[OW-1:6] == '0) && (off[1:0] == 2'b00)
                     && (reg_idx <= 4'd8);

`ifdef DFR_AXI_BUSY_PROTECT_EN
    assign wr_blocked = busy && (is_mem || (reg_ok && reg_idx >= 4'd2));
    assign unused_in  = ^S_AXI_WSTRB;
`else
    assign wr_blocked = 1'b0;
    assign unused_in  = ^{S_AXI_WSTRB, busy};
`endif

    assign wr_go = (state == WR_ACK) && !wr_blocked;

    assign S_AXI_AWREADY = (state == WR_ACK);
    assign S_AXI_WREADY  = (state == WR_ACK);
    assign S_AXI_BVALID  = (state == WR_RESP);
    assign S_AXI_ARREADY = (state == RD_ACK);
    assign S_AXI_RVALID  = (state == RD_RESP);
    assign S_AXI_BRESP   = resp_q;
    assign S_AXI_RRESP   = resp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign mem_sel   = is_mem ? 2'(region - 6'h01) : 2'b00;
    assign mem_addr  = addr_q[MEM_ADDR_WIDTH+1:2];
    assign mem_wdata = wdata_q[31:0];
    assign mem_we    = wr_go && is_mem;
    assign mem_re    = (state == RD_ACK) && is_mem;
    assign start     = (state == WR_ACK) && reg_ok && (reg_idx == 4'd0)
                       && wdata_q[0];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                // a complete write beats a simultaneous read
                if (S_AXI_AWVALID && S_AXI_WVALID) state_nxt = WR_ACK;
                else if (S_AXI_ARVALID)             state_nxt = RD_ACK;
            end
            WR_ACK:  state_nxt = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) state_nxt = IDLE;
            RD_ACK:  state_nxt = RD_MEM;
            RD_MEM:  state_nxt = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
        end else begin
            if (state == IDLE) begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    addr_q  <= S_AXI_AWADDR;
                    wdata_q <= S_AXI_WDATA;
                end else if (S_AXI_ARVALID) begin
                    addr_q <= S_AXI_ARADDR;
                end
            end
            if (state == WR_ACK)
                resp_q <= (!(is_reg || is_mem) || wr_blocked) ? 2'b10 : 2'b00;
            if (state == RD_ACK)
                resp_q <= (is_reg || is_mem) ? 2'b00 : 2'b10;
            if (state == RD_MEM)
                rdata_q <= is_mem ? mem_rdata : reg_rd;
        end
    end

    always_comb begin
        reg_rd = '0;
        case (reg_idx)
            4'd0: reg_rd = ctrl_reg;
            4'd1: reg_rd = debug_in;
            4'd2: reg_rd = num_init_samples;
            4'd3: reg_rd = num_train_samples;
            4'd4: reg_rd = num_test_samples;
            4'd5: reg_rd = num_steps_per_sample;
            4'd6: reg_rd = num_init_steps;
            4'd7: reg_rd = num_train_steps;
            4'd8: reg_rd = num_test_steps;
            default: reg_rd = '0;
        endcase
        if (!reg_ok) reg_rd = '0;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_reg             <= '0;
            num_init_samples     <= '0;
            num_train_samples    <= '0;
            num_test_samples     <= '0;
            num_steps_per_sample <= '0;
            num_init_steps       <= '0;
            num_train_steps      <= '0;
            num_test_steps       <= '0;
        end else if (wr_go && reg_ok) begin
            case (reg_idx)
                4'd0: ctrl_reg             <= wdata_q[31:0];
                4'd2: num_init_samples     <= wdata_q[31:0];
                4'd3: num_train_samples    <= wdata_q[31:0];
                4'd4: num_test_samples     <= wdata_q[31:0];
                4'd5: num_steps_per_sample <= wdata_q[31:0];
                4'd6: num_init_steps       <= wdata_q[31:0];
                4'd7: num_train_steps      <= wdata_q[31:0];
                4'd8: num_test_steps       <= wdata_q[31:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dfr_axi_cfg_slave.sv
// tb_dfr_axi_cfg_slave: directed and randomized checks of the AXI config slave
// against a register/memory reference model.
module tb_dfr_axi_cfg_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [29:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] ctrl_reg, n_is, n_trs, n_tes, n_sps, n_ist, n_trst, n_test;
    logic        start;
    logic [31:0] debug_in = '0;
    logic        busy = 1'b0;
    logic [1:0]  mem_sel;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dfr_axi_cfg_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_reg(ctrl_reg), .num_init_samples(n_is), .num_train_samples(n_trs),
        .num_test_samples(n_tes), .num_steps_per_sample(n_sps),
        .num_init_steps(n_ist), .num_train_steps(n_trst), .num_test_steps(n_test),
        .start(start), .debug_in(debug_in), .busy(busy),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // memory environment and strobe monitor
    logic [31:0] tb_mem [4][256];
    int          we_cnt = 0, re_cnt = 0, both_cnt = 0, start_cnt = 0;
    logic [1:0]  we_sel, re_sel;
    logic [15:0] we_addr, re_addr;
    logic [31:0] we_data;

    always @(posedge clk) begin
        if (mem_we && mem_re) both_cnt++;
        if (start) start_cnt++;
        if (mem_we) begin
            we_cnt++;
            we_sel = mem_sel; we_addr = mem_addr; we_data = mem_wdata;
            tb_mem[mem_sel][mem_addr[7:0]] = mem_wdata;
        end
        if (mem_re) begin
            re_cnt++;
            re_sel = mem_sel; re_addr = mem_addr;
            mem_rdata <= tb_mem[mem_sel][mem_addr[7:0]];
        end
    end

    // reference model
    logic [31:0] ref_mem [4][256];
    logic [31:0] ref_regs [9];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input int off, input logic [31:0] dbg);
        if (off == 4) return dbg;
        if (off % 4 == 0 && off <= 32) return ref_regs[off / 4];
        return 32'h0;
    endfunction

    task automatic do_write(input logic [29:0] a, input logic [31:0] d,
                            output logic [1:0] resp, output int lat);
        int n;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        lat = n;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk("wr_bvalid_seen", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [29:0] a, input int hold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output logic stable);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        chk("rd_arready_lat", n, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        lat = n;
        data = rdata; resp = rresp; stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!rvalid || rdata !== data || rresp !== resp) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        if (rvalid) stable = 1'b0;
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d, v;
        logic        st;
        int          lat, w0, s0, r0;

        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 256; i++) begin
                tb_mem[s][i] = $urandom;
                ref_mem[s][i] = tb_mem[s][i];
            end
        tb_mem[3][2] = 32'h1234; ref_mem[3][2] = 32'h1234;
        for (int i = 0; i < 9; i++) ref_regs[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'b0, awready}, 0);
        chk("rst_bvalid", {31'b0, bvalid}, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobes", {28'b0, mem_we, mem_re, start, arready}, 0);
        chk("rst_ctrl", ctrl_reg, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_write(30'h08, 32'd100, r, lat);
        ref_regs[2] = 100;
        chk("wr08_resp", r, 0);
        chk("wr_ready_lat", lat, 1);
        chk("wr08_reg", n_is, 100);
        do_read(30'h08, 0, v, r, lat, st);
        chk("rd08_data", v, 100);
        chk("rd08_resp", r, 0);
        chk("rd_rvalid_lat", lat, 2);

        w0 = we_cnt;
        do_write(30'h0100_0010, 32'hFFFF_FF9C, r, lat);
        ref_mem[0][4] = 32'hFFFF_FF9C;
        chk("memwr_count", we_cnt - w0, 1);
        chk("memwr_sel", we_sel, 0);
        chk("memwr_addr", we_addr, 4);
        chk("memwr_data", we_data, 32'hFFFF_FF9C);
        chk("memwr_resp", r, 0);

        r0 = re_cnt;
        do_read(30'h0400_0008, 5, v, r, lat, st);
        chk("memrd_count", re_cnt - r0, 1);
        chk("memrd_sel", re_sel, 3);
        chk("memrd_addr", re_addr, 2);
        chk("memrd_data", v, 32'h1234);
        chk("memrd_stable", {31'b0, st}, 1);

        s0 = start_cnt;
        do_write(30'h00, 32'd1, r, lat);
        ref_regs[0] = 1;
        chk("start_pulse", start_cnt - s0, 1);
        chk("ctrl_val", ctrl_reg, 1);
        s0 = start_cnt;
        do_write(30'h00, 32'd0, r, lat);
        ref_regs[0] = 0;
        chk("start_none", start_cnt - s0, 0);
        debug_in = 32'hA5;
        do_read(30'h04, 0, v, r, lat, st);
        chk("debug_rd", v, 32'hA5);
        do_write(30'h04, 32'h55, r, lat);
        chk("debug_wr_resp", r, 0);

        // write and read offered together: the write must land first
        awaddr = 30'h0C; wdata = 32'd77; araddr = 30'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        chk("sim_awready", {31'b0, awready}, 1);
        chk("sim_arready", {31'b0, arready}, 0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("sim_bvalid", {31'b0, bvalid}, 1);
        @(posedge clk); #1;
        chk("sim_b_onecycle", {31'b0, bvalid}, 0);
        bready = 1'b0;
        lat = 0;
        while (!arready && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("sim_ar_after_wr", {31'b0, arready}, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("sim_rdata", rdata, 77);
        ref_regs[3] = 77;
        @(posedge clk); #1;
        chk("sim_r_onecycle", {31'b0, rvalid}, 0);
        rready = 1'b0;

        w0 = we_cnt;
        do_write(30'h0500_0000, 32'h1111, r, lat);
        chk("unmap_wr_resp", r, 2);
        chk("unmap_wr_drop", we_cnt - w0, 0);
        do_read(30'h0500_0000, 0, v, r, lat, st);
        chk("unmap_rd_resp", r, 2);
        chk("unmap_rd_data", v, 0);
        do_read(30'h24, 0, v, r, lat, st);
        chk("reg_other_rd", {v[29:0], r}, 0);

        busy = 1'b1;
        w0 = we_cnt;
        do_write(30'h0300_0000, 32'hDEAD_BEEF, r, lat);
`ifdef DFR_AXI_BUSY_PROTECT_EN
        chk("busy_resp", r, 2);
        chk("busy_we", we_cnt - w0, 0);
`else
        ref_mem[2][0] = 32'hDEAD_BEEF;
        chk("busy_resp", r, 0);
        chk("busy_we", we_cnt - w0, 1);
`endif
        busy = 1'b0;

        for (int t = 0; t < 60; t++) begin
            int          rg, off, word, mid;
            logic [5:0]  reg6;
            logic [29:0] a;
            logic        is_wr;
            rg = $urandom_range(0, 6);
            reg6 = (rg <= 4) ? 6'(rg) : (rg == 5 ? 6'h05 : 6'h3F);
            off = $urandom_range(0, 12) * 4;
            word = $urandom_range(0, 255);
            mid = $urandom_range(0, 255);
            a = (rg == 0) ? {reg6, 24'(off)}
                          : {reg6, 6'($urandom_range(0, 63)), 8'(mid), 8'(word), 2'b00};
            is_wr = $urandom_range(0, 1) == 1;
            d = $urandom;
            debug_in = $urandom;
            w0 = we_cnt; r0 = re_cnt; s0 = start_cnt;
            if (is_wr) begin
                do_write(a, d, r, lat);
                chk("rnd_wr_resp", r, (rg >= 5) ? 2 : 0);
                if (rg >= 1 && rg <= 4) begin
                    ref_mem[rg - 1][word] = d;
                    chk("rnd_we_cnt", we_cnt - w0, 1);
                    chk("rnd_we_loc", {14'b0, we_sel, we_addr}, {14'b0, 2'(rg - 1), 8'(mid), 8'(word)});
                    chk("rnd_we_data", we_data, d);
                end else begin
                    chk("rnd_we_none", we_cnt - w0, 0);
                end
                if (rg == 0 && off % 4 == 0 && off <= 32 && off != 4) ref_regs[off / 4] = d;
                chk("rnd_start", start_cnt - s0, (rg == 0 && off == 0) ? int'(d[0]) : 0);
            end else begin
                do_read(a, $urandom_range(0, 2), v, r, lat, st);
                chk("rnd_rd_resp", r, (rg >= 5) ? 2 : 0);
                chk("rnd_rd_data", v, (rg == 0) ? exp_reg(off, debug_in) :
                                      (rg <= 4) ? ref_mem[rg - 1][word] : 32'h0);
                chk("rnd_re_cnt", re_cnt - r0, (rg >= 1 && rg <= 4) ? 1 : 0);
                chk("rnd_rd_stable", {31'b0, st}, 1);
            end
        end

        chk("out_ctrl", ctrl_reg, ref_regs[0]);
        chk("out_is", n_is, ref_regs[2]);
        chk("out_trs", n_trs, ref_regs[3]);
        chk("out_tes", n_tes, ref_regs[4]);
        chk("out_sps", n_sps, ref_regs[5]);
        chk("out_ist", n_ist, ref_regs[6]);
        chk("out_trst", n_trst, ref_regs[7]);
        chk("out_test", n_test, ref_regs[8]);
        chk("we_re_overlap", both_cnt, 0);

        // reset while the read is waiting on memory data
        araddr = 30'h0200_0010; arvalid = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!arready && lat < 20);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'b0, rvalid}, 0);
        chk("rst_mid_regs", n_is, 0);
        for (int i = 0; i < 9; i++) ref_regs[i] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        st = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rvalid || arready || awready) st = 1'b1;
        end
        chk("rst_mid_quiet", {31'b0, st}, 0);
        do_read(30'h0200_0010, 0, v, r, lat, st);
        chk("post_rst_rd", v, ref_mem[1][4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
